pixel_packer: RTL
=================

// Module: pixel_packer
// PURPOSE
//  Stage directly downstream of the multi-core pixel buffer. Takes one RGB888 pixel per handshake.
//  Packs every 4 pixels (12 bytes) into 3 x 32-bit AXI4-Stream words for the video DMA.
//  Marks the first word of a frame with tuser (SOF) and the last word of each line with tlast (EOL).
// PARAMETERS
//  X_SIZE  640  pixels per line; must be a multiple of 4 and >= 4
//  Y_SIZE  480  lines per frame; >= 1
// PORTS
//  aclk               in   1   clock; all logic on rising edge
//  areset             in   1   synchronous reset, active-high
//  in_r/in_g/in_b     in   8   pixel colour channels
//  in_valid           in   1   pixel offered
//  in_stream_ready    out  1   packer accepts pixel this cycle
//  out_stream_tdata   out  32  packed word; byte0 = bits[7:0]
//  out_stream_tvalid  out  1   word valid
//  out_stream_tready  in   1   downstream accepts word
//  out_stream_tlast   out  1   last word of a line
//  out_stream_tuser   out  1   first word of a frame
//  frame_done         out  1   1-cycle pulse when the final word of a frame is accepted downstream
// BEHAVIOUR
//  - Reset: tvalid, tlast, tuser, frame_done = 0; tdata = 0; phase = 0; x = 0; y = 0; partial bytes cleared.
//  - Reset mid-frame discards any held word and partial bytes. The next accepted pixel is x = 0, y = 0.
//  - Pixel accepted when in_valid && in_stream_ready.
//  - in_stream_ready = (phase == 0) || !tvalid || tready. Purely combinational; no dependency on in_valid.
//  - Byte stream order: pixel p contributes R, G, B at bytes 3p, 3p+1, 3p+2.
//  - Phase FSM P0..P3, advancing on each accepted pixel (P3 wraps to P0):
//      P0: store R0, G0, B0 in partial; emits no word
//      P1: word {R1, B0, G0, R0}; store G1, B1
//      P2: word {G2, R2, B1, G1}; store B2
//      P3: word {B3, G3, R3, B2}
//  - Output register:
//      loaded on the edge that accepts a word-producing pixel; tvalid = 1 from the next cycle
//      held stable while tvalid && !tready
//      cleared on tready unless a new word loads on the same edge
//  - Throughput: 1 pixel/cycle with tready held high. Latency: pixel accept to tvalid = 1 cycle.
//  - Position counters:
//      x increments per accepted pixel
//      at x == X_SIZE-1, x wraps to 0 and y increments
//      at y == Y_SIZE-1 and end of line, y wraps to 0
//  - tuser = 1 on the word produced by pixel x == 1, y == 0; 0 otherwise.
//  - tlast = 1 on the word produced by pixel x == X_SIZE-1; 0 otherwise.
//  - frame_done pulses the cycle after a tvalid && tready handshake whose word has tlast = 1 and came from line Y_SIZE-1.
//  - Simultaneous events: tready plus a new word on the same edge -> the old word leaves and the new word loads, no bubble.
//  - in_valid without acceptance: no state change. in_r/in_g/in_b are ignored when not accepted.
//  - Back-pressure in P0 still accepts the pixel, because it only writes partial. The next pixel then stalls until tready.
// TESTING
//  1 X_SIZE=4, Y_SIZE=2, tready=1; pixels (01,02,03) (04,05,06) (07,08,09) (0A,0B,0C)
//    -> tdata 0x04030201 (tuser=1), 0x08070605, 0x0C0B0A09 (tlast=1).
//  2 Same frame continued with line 1 of 4 pixels
//    -> 3 words; tuser=0 on all; tlast on 3rd; frame_done pulses once, 1 cycle after 3rd handshake.
//  3 tready=0 for 5 cycles while pixels stream
//    -> tdata/tvalid/tlast stable; in_stream_ready=0 except in P0; no word lost or duplicated.
//  4 Toggle tready every cycle over a 2x4x4 frame
//    -> 24 words in order, matching the reference model byte-for-byte.
//  5 Assert areset after 2 pixels of a line
//    -> outputs 0 next cycle; next pixel treated as x=0, y=0 and its word carries tuser=1.
//  6 in_valid with gaps, tready=1
//    -> words emitted only on P1/P2/P3 accepts; counters advance only on accepts.

Source files
------------

// File: rtl/pixel_packer_if.sv
// rtl/pixel_packer_if.sv - pixel input and packed AXI4-Stream output bundle for pixel_packer
interface pixel_packer_if;
   logic [7:0]  in_r;
   logic [7:0]  in_g;
   logic [7:0]  in_b;
   logic        in_valid;
   logic        in_stream_ready;
   logic [31:0] out_stream_tdata;
   logic        out_stream_tvalid;
   logic        out_stream_tready;
   logic        out_stream_tlast;
   logic        out_stream_tuser;
   logic        frame_done;

   // Environment side: offers pixels, consumes packed words.
   modport master (
      output in_r, in_g, in_b, in_valid, out_stream_tready,
      input  in_stream_ready, out_stream_tdata, out_stream_tvalid,
      input  out_stream_tlast, out_stream_tuser, frame_done
   );

   // Packer side.
   modport slave (
      input  in_r, in_g, in_b, in_valid, out_stream_tready,
      output in_stream_ready, out_stream_tdata, out_stream_tvalid,
      output out_stream_tlast, out_stream_tuser, frame_done
   );
endinterface

// File: rtl/pixel_packer.sv
// rtl/pixel_packer.sv - packs RGB888 pixels, 4 pixels into 3 32-bit stream words with SOF/EOL
module pixel_packer #(
   parameter int X_SIZE = 640,
   parameter int Y_SIZE = 480
) (
   input  logic           aclk,
   input  logic           areset,
   pixel_packer_if.slave  bus
);

   localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
   localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

   typedef enum logic [1:0] {P0, P1, P2, P3} phase_e;

   phase_e        phase_q, phase_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [23:0]   part_q, part_d;
   logic [31:0]   word_d;
   logic [31:0]   tdata_q;
   logic          tvalid_q;
   logic          tlast_q;
   logic          tuser_q;
   logic          last_line_q;
   logic          frame_done_q;
   logic          ready;
   logic          accept;
   logic          load;

   always_ff @(posedge aclk) begin
      if (areset) begin
         phase_q <= P0;
      end else begin
         phase_q <= phase_d;
      end
   end

   always_comb begin
      phase_d = phase_q;
      if (accept) begin
         unique case (phase_q)
            P0: phase_d = P1;
            P1: phase_d = P2;
            P2: phase_d = P3;
            P3: phase_d = P0;
         endcase
      end
   end

   // P0 only fills the partial register, so it never needs the output slot.
   always_comb begin
      ready  = (phase_q == P0) || !tvalid_q || bus.out_stream_tready;
      accept = bus.in_valid && ready;
      load   = accept && (phase_q != P0);
      word_d = '0;
      part_d = part_q;
      unique case (phase_q)
         P0: part_d = {bus.in_b, bus.in_g, bus.in_r};
         P1: begin
            word_d = {bus.in_r, part_q};
            part_d = {8'h00, bus.in_b, bus.in_g};
         end
         P2: begin
            word_d = {bus.in_g, bus.in_r, part_q[15:0]};
            part_d = {16'h0000, bus.in_b};
         end
         P3: word_d = {bus.in_b, bus.in_g, bus.in_r, part_q[7:0]};
      endcase
      if (!accept) begin
         part_d = part_q;
      end
   end

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (accept) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
         end else begin
            x_d = x_q + XW'(1);
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         part_q       <= '0;
         x_q          <= '0;
         y_q          <= '0;
         tdata_q      <= '0;
         tvalid_q     <= 1'b0;
         tlast_q      <= 1'b0;
         tuser_q      <= 1'b0;
         last_line_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         part_q       <= part_d;
         x_q          <= x_d;
         y_q          <= y_d;
         frame_done_q <= tvalid_q && bus.out_stream_tready && tlast_q && last_line_q;
         // A new word may replace one leaving on this same edge: no bubble.
         if (load) begin
            tdata_q     <= word_d;
            tvalid_q    <= 1'b1;
            tlast_q     <= (x_q == X_LAST);
            tuser_q     <= (x_q == XW'(1)) && (y_q == '0);
            last_line_q <= (y_q == Y_LAST);
         end else if (bus.out_stream_tready) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
         end
      end
   end

   assign bus.in_stream_ready   = ready;
   assign bus.out_stream_tdata  = tdata_q;
   assign bus.out_stream_tvalid = tvalid_q;
   assign bus.out_stream_tlast  = tlast_q;
   assign bus.out_stream_tuser  = tuser_q;
   assign bus.frame_done        = frame_done_q;

endmodule
